// File: rtl/statemachine.sv
// statemachine: Moore controller sequencing MOV/ALU instructions through the datapath.
// Define ILLEGAL_OP_TRAP_EN to hold unsupported opcodes in DECODE until reset.
module statemachine #(
  parameter logic [15:0] MDATA_VAL = 16'h0000,
  parameter logic [7:0]  PC_VAL    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  input  logic        s,
  output logic        w,
  output logic [2:0]  nsel,
  output logic [3:0]  vsel,
  output logic [15:0] mdata,
  output logic [7:0]  PC,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic [1:0]  shift,
  output logic        bsel,
  output logic        asel,
  output logic        loadc,
  output logic        loads
);
  typedef enum logic [6:0] {
    WAIT     = 7'b0000001,
    DECODE   = 7'b0000010,
    GETA     = 7'b0000100,
    GETB     = 7'b0001000,
    EXEC     = 7'b0010000,
    WRITEREG = 7'b0100000,
    WRITEIMM = 7'b1000000
  } state_t;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t BAD = DECODE;
`else
  localparam state_t BAD = WAIT;
`endif
  state_t state, nxt;
  logic mov, alu, mov_imm, mov_reg, mvn, cmp;
  assign mov     = opcode == 3'b110;
  assign alu     = opcode == 3'b101;
  assign mov_imm = mov && op == 2'b10;
  assign mov_reg = mov && op == 2'b00;
  assign mvn     = alu && op == 2'b11;
  assign cmp     = alu && op == 2'b01;
  assign mdata   = MDATA_VAL;
  assign PC      = PC_VAL;
  assign bsel    = 1'b0;
  always_comb begin
    nxt = WAIT;
    case (state)
      WAIT:    nxt = s ? DECODE : WAIT;
      DECODE:  nxt = mov_imm ? WRITEIMM : (mov_reg || mvn) ? GETB : alu ? GETA : BAD;
      GETA:    nxt = GETB;
      GETB:    nxt = EXEC;
      EXEC:    nxt = cmp ? WAIT : WRITEREG;
      default: nxt = WAIT;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT;
      w     <= 1'b1;
      nsel  <= 3'b000;
      vsel  <= 4'b0001;
      write <= 1'b0;
      loada <= 1'b0;
      loadb <= 1'b0;
      shift <= 2'b00;
      asel  <= 1'b0;
      loadc <= 1'b0;
      loads <= 1'b0;
    end else begin
      state <= nxt;
      w     <= nxt == WAIT;
      nsel  <= (nxt == GETA || nxt == WRITEIMM) ? 3'b100 : nxt == GETB ? 3'b001 :
               nxt == WRITEREG ? 3'b010 : 3'b000;
      vsel  <= nxt == WRITEIMM ? 4'b0100 : 4'b0001;
      write <= nxt == WRITEREG || nxt == WRITEIMM;
      loada <= nxt == GETA;
      loadb <= nxt == GETB;
      shift <= {1'b0, nxt == EXEC};
      asel  <= nxt == EXEC && (mov_reg || mvn);
      loadc <= nxt == EXEC && !cmp;
      loads <= nxt == EXEC && cmp;
    end
  end
endmodule

// File: tb/tb_statemachine.sv
// tb_statemachine: random instruction stream checked against a per-instruction phase-list model.
module tb_statemachine;
  logic clk = 0, reset = 0, s = 0, w, write, loada, loadb, bsel, asel, loadc, loads;
  logic [2:0] opcode = 0, nsel;
  logic [1:0] op = 0, shift;
  logic [3:0] vsel;
  logic [15:0] mdata;
  logic [7:0] PC;
  int checks = 0, failures = 0;
  logic [16:0] q[$];
  bit trapped = 0;
  statemachine dut (.clk(clk), .reset(reset), .opcode(opcode), .op(op), .s(s), .w(w),
    .nsel(nsel), .vsel(vsel), .mdata(mdata), .PC(PC), .write(write), .loada(loada),
    .loadb(loadb), .shift(shift), .bsel(bsel), .asel(asel), .loadc(loadc), .loads(loads));
  always #5 clk = ~clk;
  function automatic logic [16:0] v(input logic w_, input logic [2:0] ns, input logic [3:0] vs,
    input logic wr, la, lb, input logic [1:0] sh, input logic as, lc, ls);
    return {w_, ns, vs, wr, la, lb, sh, 1'b0, as, lc, ls};
  endfunction
  function automatic logic [16:0] idle();
    return v(1, 3'b000, 4'b0001, 0, 0, 0, 2'b00, 0, 0, 0);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected output vector for each cycle of one instruction, starting with DECODE.
  task automatic start(input logic [2:0] oc, input logic [1:0] o);
    logic [16:0] dec, geta, getb, wrreg, wrimm;
    bit mov = oc == 3'b110, alu = oc == 3'b101;
    dec   = v(0, 3'b000, 4'b0001, 0, 0, 0, 2'b00, 0, 0, 0);
    geta  = v(0, 3'b100, 4'b0001, 0, 1, 0, 2'b00, 0, 0, 0);
    getb  = v(0, 3'b001, 4'b0001, 0, 0, 1, 2'b00, 0, 0, 0);
    wrreg = v(0, 3'b010, 4'b0001, 1, 0, 0, 2'b00, 0, 0, 0);
    wrimm = v(0, 3'b100, 4'b0100, 1, 0, 0, 2'b00, 0, 0, 0);
    q = '{dec};
    if (mov && o == 2'b10) q.push_back(wrimm);
    else if ((mov && o == 2'b00) || (alu && o == 2'b11)) begin
      q.push_back(getb);
      q.push_back(v(0, 3'b000, 4'b0001, 0, 0, 0, 2'b01, 1, 1, 0));
      q.push_back(wrreg);
    end else if (alu) begin
      q.push_back(geta);
      q.push_back(getb);
      if (o == 2'b01) q.push_back(v(0, 3'b000, 4'b0001, 0, 0, 0, 2'b01, 0, 0, 1));
      else begin
        q.push_back(v(0, 3'b000, 4'b0001, 0, 0, 0, 2'b01, 0, 1, 0));
        q.push_back(wrreg);
      end
    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
      trapped = 1;
`endif
    end
  endtask
  function automatic logic [16:0] outs();
    return {w, nsel, vsel, write, loada, loadb, shift, bsel, asel, loadc, loads};
  endfunction
  task automatic step(input logic s_, input logic [2:0] oc, input logic [1:0] o);
    @(posedge clk);
    if (q.size() != 0) begin
      if (!trapped) void'(q.pop_front());
    end else if (s) start(opcode, op);
    #1 s = s_;
    if (q.size() == 0) begin
      opcode = oc;
      op = o;
    end
    @(negedge clk);
    chk("outs", outs(), q.size() != 0 ? q[0] : idle());
    chk("const", {mdata, PC}, 24'h000000);
  endtask
  task automatic settle();
    repeat (10) if (q.size() != 0) step(0, 3'b000, 2'b00);
    chk("idle_reached", q.size(), 0);
  endtask
  initial begin
    logic [2:0] ocs[6] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    logic [1:0] ops[6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    #13 chk("reset_outs", outs(), idle());
    chk("reset_const", {mdata, PC}, 24'h000000);
    @(negedge clk) reset = 1;
    step(1, 3'b110, 2'b10);
    repeat (3) step(0, 3'b000, 2'b00);
    step(1, 3'b110, 2'b00);
    repeat (5) step(0, 3'b000, 2'b00);
    step(1, 3'b101, 2'b01);
    repeat (5) step(0, 3'b000, 2'b00);
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 5);
      logic [2:0] oc = ocs[k];
      logic [1:0] o = ops[k];
`ifndef ILLEGAL_OP_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        oc = 3'($urandom);
        o = 2'($urandom);
      end
`endif
      step(1'($urandom), oc, o);
    end
    settle();
    step(1, 3'b101, 2'b00);
    repeat (4) step(0, 3'b000, 2'b00);
    chk("add_exec", outs(), v(0, 3'b000, 4'b0001, 0, 0, 0, 2'b01, 0, 1, 0));
    #1 reset = 0;
    #1 chk("async_reset", outs(), idle());
    chk("async_const", {mdata, PC}, 24'h000000);
    q.delete();
    s = 1;
    @(posedge clk);
    #1 chk("reset_hold", outs(), idle());
    s = 0;
    @(negedge clk) reset = 1;
    step(1, 3'b000, 2'b00);
    repeat (6) step(0, 3'b000, 2'b00);
    #1 reset = 0;
    #1 chk("trap_release", outs(), idle());
    q.delete();
    trapped = 0;
    @(negedge clk) reset = 1;
    step(0, 3'b000, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
